modbus_resp_tx: RTL and testbench

Response framer for the Modbus RTU slave. It sits directly downstream of the `exceptions` checker and directly upstream of `uart_byte_tx`. On each `exception_done` it latches the request fields and builds one response frame:
- an exception reply,
- an echo for function 0x06, or
- a register read reply for function 0x03.

It computes CRC-16 (Modbus) on the fly and streams the frame byte by byte through the UART transmitter handshake.

---
 rtl/modbus_pkg.sv | 38 +++
 rtl/modbus_resp_tx_if.sv | 26 ++
 rtl/modbus_crc_serial.sv | 23 ++
 rtl/modbus_resp_tx.sv | 193 +++++++++++++++++++
 tb/tb_modbus_resp_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants, framer state encoding and the CRC-16 byte step.
package modbus_pkg;

    localparam logic [7:0] FC_READ_HOLD    = 8'h03;
    localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;

    localparam logic [7:0] EX_NONE      = 8'h00;
    localparam logic [7:0] EX_ILL_FUNC  = 8'h01;
    localparam logic [7:0] EX_ILL_ADDR  = 8'h02;
    localparam logic [7:0] EX_ILL_VALUE = 8'h03;
    localparam logic [7:0] EX_DEV_FAIL  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } resp_state_t;

    typedef enum logic [1:0] {
        FR_EXC,
        FR_ECHO,
        FR_READ
    } frame_kind_t;

    // Reflected polynomial 0xA001, one full byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data_byte);
        logic [15:0] c;
        c = crc ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_resp_tx_if.sv
// Request, register-read and UART-byte handshake signals of the response framer.
interface modbus_resp_tx_if;
    logic        exception_done;
    logic [7:0]  exception;
    logic [7:0]  func_code;
    logic [15:0] addr;
    logic [15:0] data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_busy;
    logic        resp_done;

    modport slave (
        input  exception_done, exception, func_code, addr, data, reg_rd_data, tx_done,
        output reg_rd_en, reg_rd_addr, tx_start, tx_data, resp_busy, resp_done
    );

    modport master (
        output exception_done, exception, func_code, addr, data, reg_rd_data, tx_done,
        input  reg_rd_en, reg_rd_addr, tx_start, tx_data, resp_busy, resp_done
    );
endinterface

// File: rtl/modbus_crc_serial.sv
// Byte-serial Modbus CRC-16 accumulator; init has priority over update.
module modbus_crc_serial
    import modbus_pkg::*;
(
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        update,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc
);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 16'hFFFF;
        end else if (init) begin
            crc <= 16'hFFFF;
        end else if (update) begin
            crc <= crc16_byte(crc, data_byte);
        end
    end

endmodule

// File: rtl/modbus_resp_tx.sv
// Modbus RTU response framer: builds EXC / ECHO / READ frames and streams them
// byte by byte to the UART transmitter with CRC-16 appended low byte first.
//
// state  | meaning
// IDLE   | waiting for exception_done, request fields latched on it
// DECIDE | classify request: drop, exception, echo or register read
// FETCH  | read strobe / capture pairs filling the read buffer
// SEND   | tx_start pulse for byte[idx], fold it into the CRC
// WAIT   | hold tx_data until tx_done, then advance idx
// DONE   | resp_done pulse, CRC reinitialised
module modbus_resp_tx
    import modbus_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int          MAX_REGS  = 4
) (
    input  logic            sys_clk,
    input  logic            reset_n,
    modbus_resp_tx_if.slave bus
);

    localparam int          BUF_BYTES = 2 * MAX_REGS;
    localparam int          MAX_LEN   = 5 + BUF_BYTES;
    localparam int          IDX_W     = $clog2(MAX_LEN + 1);
    localparam int          RD_W      = $clog2(MAX_REGS + 1);
    localparam logic [15:0] MAX_QTY   = 16'(MAX_REGS);

    resp_state_t              state_q, state_d;
    frame_kind_t              kind_q, dec_kind;
    logic [7:0]               func_q, exc_q, code_q, dec_code;
    logic [15:0]              addr_q, data_q;
    logic [IDX_W-1:0]         len_q, idx_q, idx_nxt, dec_len;
    logic [RD_W-1:0]          rd_left_q, rd_ptr;
    logic                     rd_phase_q;
    logic [8*BUF_BYTES-1:0]   rd_buf;
    logic                     dec_drop;
    logic [7:0]               cur_byte;
    logic                     is_crc_byte;
    logic [15:0]              crc;

    assign idx_nxt     = idx_q + IDX_W'(1);
    assign rd_ptr      = RD_W'(data_q) - rd_left_q;
    assign is_crc_byte = (idx_q >= len_q - IDX_W'(2));

    // First matching rule wins; codes above EX_DEV_FAIL mean the request is dropped silently.
    always_comb begin
        dec_drop = 1'b0;
        dec_kind = FR_EXC;
        dec_code = exc_q;
        if (exc_q > EX_DEV_FAIL) begin
            dec_drop = 1'b1;
        end else if (exc_q != EX_NONE) begin
            dec_kind = FR_EXC;
            dec_code = exc_q;
        end else if (func_q == FC_READ_HOLD) begin
            if (data_q == 16'h0000 || data_q > MAX_QTY) begin
                dec_kind = FR_EXC;
                dec_code = EX_ILL_VALUE;
            end else begin
                dec_kind = FR_READ;
            end
        end else if (func_q == FC_WRITE_SINGLE) begin
            dec_kind = FR_ECHO;
        end else begin
            dec_kind = FR_EXC;
            dec_code = EX_ILL_FUNC;
        end
    end

    always_comb begin
        dec_len = IDX_W'(5);
        if (dec_kind == FR_ECHO) begin
            dec_len = IDX_W'(8);
        end else if (dec_kind == FR_READ) begin
            dec_len = IDX_W'(5) + IDX_W'({data_q[RD_W-1:0], 1'b0});
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.exception_done) state_d = ST_DECIDE;
            ST_DECIDE: begin
                if (dec_drop) begin
                    state_d = ST_DONE;
                end else if (dec_kind == FR_READ) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_FETCH:  if (rd_phase_q && rd_left_q == RD_W'(1)) state_d = ST_SEND;
            ST_SEND:   state_d = ST_WAIT;
            ST_WAIT:   if (bus.tx_done) state_d = (idx_nxt == len_q) ? ST_DONE : ST_SEND;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= FR_EXC;
            func_q     <= '0;
            exc_q      <= '0;
            code_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rd_left_q  <= '0;
            rd_phase_q <= 1'b0;
            rd_buf     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.exception_done) begin
                        func_q <= bus.func_code;
                        exc_q  <= bus.exception;
                        addr_q <= bus.addr;
                        data_q <= bus.data;
                    end
                end
                ST_DECIDE: begin
                    kind_q     <= dec_kind;
                    code_q     <= dec_code;
                    len_q      <= dec_len;
                    idx_q      <= '0;
                    rd_left_q  <= RD_W'(data_q);
                    rd_phase_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (!rd_phase_q) begin
                        rd_phase_q <= 1'b1;
                    end else begin
                        rd_phase_q <= 1'b0;
                        rd_left_q  <= rd_left_q - RD_W'(1);
                        rd_buf[16*int'(rd_ptr) +: 8]     <= bus.reg_rd_data[15:8];
                        rd_buf[16*int'(rd_ptr) + 8 +: 8] <= bus.reg_rd_data[7:0];
                    end
                end
                ST_WAIT: if (bus.tx_done) idx_q <= idx_nxt;
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_byte = '0;
        if (idx_q == '0) begin
            cur_byte = SLAVE_ADDR;
        end else if (idx_q == len_q - IDX_W'(2)) begin
            cur_byte = crc[7:0];
        end else if (idx_q == len_q - IDX_W'(1)) begin
            cur_byte = crc[15:8];
        end else begin
            case (kind_q)
                FR_EXC: cur_byte = (idx_q == IDX_W'(1)) ? (func_q | 8'h80) : code_q;
                FR_ECHO: begin
                    if (idx_q == IDX_W'(1))      cur_byte = FC_WRITE_SINGLE;
                    else if (idx_q == IDX_W'(2)) cur_byte = addr_q[15:8];
                    else if (idx_q == IDX_W'(3)) cur_byte = addr_q[7:0];
                    else if (idx_q == IDX_W'(4)) cur_byte = data_q[15:8];
                    else                         cur_byte = data_q[7:0];
                end
                FR_READ: begin
                    if (idx_q == IDX_W'(1))      cur_byte = FC_READ_HOLD;
                    else if (idx_q == IDX_W'(2)) cur_byte = {data_q[6:0], 1'b0};
                    else                         cur_byte = rd_buf[8*(int'(idx_q) - 3) +: 8];
                end
                default: cur_byte = '0;
            endcase
        end
    end

    modbus_crc_serial u_crc (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .init      (state_q == ST_DONE),
        .update    (state_q == ST_SEND && !is_crc_byte),
        .data_byte (cur_byte),
        .crc       (crc)
    );

    assign bus.tx_start    = (state_q == ST_SEND);
    assign bus.tx_data     = (state_q == ST_SEND || state_q == ST_WAIT) ? cur_byte : 8'h00;
    assign bus.reg_rd_en   = (state_q == ST_FETCH) && !rd_phase_q;
    assign bus.reg_rd_addr = bus.reg_rd_en ? (addr_q + 16'(rd_ptr)) : 16'h0000;
    assign bus.resp_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.resp_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_modbus_resp_tx.sv
// Directed vector bench for modbus_resp_tx: frame bytes, read addresses, timing,
// busy-ignore and mid-frame reset.
module tb_modbus_resp_tx;

    typedef struct {
        logic [7:0]   exc;
        logic [7:0]   func;
        logic [15:0]  addr;
        logic [15:0]  data;
        int           len;
        logic [103:0] raw;
        bit           mcrc;
        int           nreads;
        logic [15:0]  rd0;
        int           start_dly;
        int           done_dly;
    } vec_t;

    logic sys_clk = 1'b0;
    logic reset_n;

    modbus_resp_tx_if bus();

    modbus_resp_tx #(.SLAVE_ADDR(8'h01), .MAX_REGS(4)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          first_start = -1;
    int          done_cyc = -1;
    logic [7:0]  cap_q[$];
    logic [15:0] rd_q[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [15:0] reg_val(input logic [15:0] a);
        if (a == 16'h0001) return 16'h1234;
        return {a[7:0], ~a[15:8]};
    endfunction

    always @(posedge sys_clk) bus.reg_rd_data <= bus.reg_rd_en ? reg_val(bus.reg_rd_addr) : 16'h0000;

    always @(negedge sys_clk) begin
        if (bus.tx_start) begin
            cap_q.push_back(bus.tx_data);
            if (first_start < 0) first_start = cyc;
        end
        if (bus.reg_rd_en) rd_q.push_back(bus.reg_rd_addr);
        if (bus.resp_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    end

    // UART model: tx_done three cycles after each tx_start
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            if (bus.tx_start === 1'b1) begin
                repeat (3) @(negedge sys_clk);
                bus.tx_done = 1'b1;
                @(negedge sys_clk);
                bus.tx_done = 1'b0;
            end else begin
                @(negedge sys_clk);
            end
        end
    end

    // Bit-serial Modbus CRC reference
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] exc, input logic [7:0] func,
                                input logic [15:0] addr, input logic [15:0] data,
                                input int len, input logic [103:0] raw, input bit mcrc,
                                input int nreads, input logic [15:0] rd0,
                                input int sdly, input int ddly);
        vec_t v;
        v.exc = exc; v.func = func; v.addr = addr; v.data = data;
        v.len = len; v.raw = raw; v.mcrc = mcrc; v.nreads = nreads;
        v.rd0 = rd0; v.start_dly = sdly; v.done_dly = ddly;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [7:0] exc, input logic [7:0] func,
                           input logic [15:0] addr, input logic [15:0] data, output int t0);
        @(negedge sys_clk);
        cap_q.delete();
        rd_q.delete();
        done_cnt    = 0;
        first_start = -1;
        done_cyc    = -1;
        bus.exception      = exc;
        bus.func_code      = func;
        bus.addr           = addr;
        bus.data           = data;
        bus.exception_done = 1'b1;
        t0 = cyc;
        @(negedge sys_clk);
        bus.exception_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, " resp_done seen"}, 32'(ok), 32'd1);
        repeat (8) @(negedge sys_clk);
    endtask

    task automatic check_echo(input string name);
        logic [63:0] echo;
        echo = 64'h0106_0001_0005_1809;
        chk({name, " length"}, cap_q.size(), 8);
        for (int k = 0; k < 8 && k < cap_q.size(); k++)
            chk($sformatf("%s byte%0d", name, k), 32'(cap_q[k]), 32'(echo[8*(7-k) +: 8]));
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int          t0;
        int          nb;
        logic [7:0]  e[13];
        logic [15:0] c;
        logic [15:0] a;
        string       tag;
        tag = $sformatf("v%0d", vi);
        nb  = v.mcrc ? v.len - 2 : v.len;
        for (int k = 0; k < nb; k++) e[k] = v.raw[8*(nb-1-k) +: 8];
        if (v.mcrc) begin
            c = 16'hFFFF;
            for (int k = 0; k < nb; k++) c = crc_ref(c, e[k]);
            e[nb]   = c[7:0];
            e[nb+1] = c[15:8];
        end
        run_req(v.exc, v.func, v.addr, v.data, t0);
        wait_done(tag);
        chk({tag, " length"}, cap_q.size(), v.len);
        for (int k = 0; k < v.len && k < cap_q.size(); k++)
            chk($sformatf("%s byte%0d", tag, k), 32'(cap_q[k]), 32'(e[k]));
        chk({tag, " read count"}, rd_q.size(), v.nreads);
        for (int i = 0; i < v.nreads && i < rd_q.size(); i++) begin
            a = v.rd0 + 16'(i);
            chk($sformatf("%s read addr%0d", tag, i), 32'(rd_q[i]), 32'(a));
        end
        if (v.len > 0) chk({tag, " first tx_start delay"}, first_start - t0, v.start_dly);
        else           chk({tag, " no tx_start"}, 32'(first_start < 0), 32'd1);
        if (v.done_dly >= 0) chk({tag, " resp_done delay"}, done_cyc - t0, v.done_dly);
        chk({tag, " resp_done count"}, done_cnt, 1);
        chk({tag, " busy after"}, 32'(bus.resp_busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[13];
        int   t0;
        int   n;
        int   done0;

        reset_n            = 1'b0;
        bus.exception_done = 1'b0;
        bus.exception      = 8'h00;
        bus.func_code      = 8'h00;
        bus.addr           = 16'h0000;
        bus.data           = 16'h0000;

        vecs[0]  = mk(8'h02, 8'h03, 16'h0000, 16'h0001, 5,  104'h01_83_02_C0_F1, 1'b0, 0, 16'h0000, 2, -1);
        vecs[1]  = mk(8'h00, 8'h06, 16'h0001, 16'h0005, 8,  104'h01_06_00_01_00_05_18_09, 1'b0, 0, 16'h0000, 2, -1);
        vecs[2]  = mk(8'h00, 8'h03, 16'h0001, 16'h0001, 7,  104'h01_03_02_12_34, 1'b1, 1, 16'h0001, 4, -1);
        vecs[3]  = mk(8'h00, 8'h03, 16'h0010, 16'h0000, 5,  104'h01_83_03, 1'b1, 0, 16'h0000, 2, -1);
        vecs[4]  = mk(8'h00, 8'h03, 16'h0010, 16'h0005, 5,  104'h01_83_03, 1'b1, 0, 16'h0000, 2, -1);
        vecs[5]  = mk(8'h00, 8'h03, 16'hFFFF, 16'h0004, 13, 104'h01_03_08_FF_00_00_FF_12_34_02_FF, 1'b1, 4, 16'hFFFF, 10, -1);
        vecs[6]  = mk(8'h01, 8'h10, 16'h0000, 16'h0000, 5,  104'h01_90_01, 1'b1, 0, 16'h0000, 2, -1);
        vecs[7]  = mk(8'h00, 8'h10, 16'h0000, 16'h0000, 5,  104'h01_90_01, 1'b1, 0, 16'h0000, 2, -1);
        vecs[8]  = mk(8'h04, 8'h06, 16'h0001, 16'h0005, 5,  104'h01_86_04, 1'b1, 0, 16'h0000, 2, -1);
        vecs[9]  = mk(8'h00, 8'h06, 16'hABCD, 16'h1234, 8,  104'h01_06_AB_CD_12_34, 1'b1, 0, 16'h0000, 2, -1);
        vecs[10] = mk(8'hFF, 8'h03, 16'h0001, 16'h0001, 0,  104'h0, 1'b0, 0, 16'h0000, -1, 2);
        vecs[11] = mk(8'h05, 8'h06, 16'h0001, 16'h0005, 0,  104'h0, 1'b0, 0, 16'h0000, -1, 2);
        vecs[12] = mk(8'h00, 8'h03, 16'h0100, 16'h0002, 9,  104'h01_03_04_00_FE_01_FE, 1'b1, 2, 16'h0100, 6, -1);

        repeat (3) @(negedge sys_clk);
        chk("reset tx_start", 32'(bus.tx_start), 32'd0);
        chk("reset tx_data", 32'(bus.tx_data), 32'd0);
        chk("reset reg_rd_en", 32'(bus.reg_rd_en), 32'd0);
        chk("reset reg_rd_addr", 32'(bus.reg_rd_addr), 32'd0);
        chk("reset resp_busy", 32'(bus.resp_busy), 32'd0);
        chk("reset resp_done", 32'(bus.resp_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Second request arriving while busy must be dropped
        run_req(8'h00, 8'h06, 16'h0001, 16'h0005, t0);
        repeat (3) @(negedge sys_clk);
        bus.exception      = 8'h02;
        bus.func_code      = 8'h03;
        bus.exception_done = 1'b1;
        @(negedge sys_clk);
        bus.exception_done = 1'b0;
        wait_done("busy");
        repeat (30) @(negedge sys_clk);
        check_echo("busy");
        chk("busy resp_done count", done_cnt, 1);

        // Reset while the fourth byte is being started
        run_req(8'h00, 8'h06, 16'h0001, 16'h0005, t0);
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(posedge sys_clk);
            #2;
            if (bus.tx_start) n++;
        end
        chk("abort reached byte 4", n, 4);
        reset_n = 1'b0;
        #1;
        chk("abort tx_start", 32'(bus.tx_start), 32'd0);
        chk("abort resp_busy", 32'(bus.resp_busy), 32'd0);
        done0 = done_cnt;
        repeat (10) @(negedge sys_clk);
        chk("abort no resp_done", done_cnt, done0);
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        run_req(8'h00, 8'h06, 16'h0001, 16'h0005, t0);
        wait_done("post-reset");
        check_echo("post-reset");
        chk("post-reset start delay", first_start - t0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
